// File: rtl/regfile.sv
// regfile: architectural register file with rename status for the Tomasulo core.
//
// Each architectural register holds a committed value, a busy flag and the ROB
// tag of its newest in-flight producer. ROB retirements write values and
// release busy flags; Dispatch renames set busy/tag; a ROB flush drops every
// busy flag. Register 0 is hardwired to zero and never busy.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   rdy                global ready; no state change while low
//   clr                ROB flush: clear all busy flags, ignore dispatch
//   Reg_write_S/rd/Reorder/result   commit port from the ROB
//   Dispatch_S/rd/Reorder           rename port from Dispatch
//   Dispatch_rs1/rs2                source indices for the read ports
//   rsN_busy/Reorder/value          combinational operand status per source

// One combinational read port. Instantiated once per source operand.
module regfile_rd_port #(
  parameter int REG_NUM    = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 rst,
  input  logic                                 rdy,
  input  logic                                 clr,
  input  logic                                 Reg_write_S,
  input  logic [4:0]                           Reg_rd,
  input  logic [ROB_WIDTH-1:0]                 Reg_Reorder,
  input  logic [DATA_WIDTH-1:0]                Reg_result,
  input  logic [4:0]                           rs,
  input  logic [REG_NUM-1:0]                   busy_arr,
  input  logic [REG_NUM-1:0][ROB_WIDTH-1:0]    tag_arr,
  input  logic [REG_NUM-1:0][DATA_WIDTH-1:0]   value_arr,
  output logic                                 busy,
  output logic [ROB_WIDTH-1:0]                 reorder,
  output logic [DATA_WIDTH-1:0]                value
);
  logic bypass;

  // A commit that retires the current producer of rs this cycle is forwarded,
  // so Dispatch never captures a tag that is about to disappear.
  assign bypass = Reg_write_S && rdy && (Reg_rd == rs) && (rs != 5'd0) &&
                  busy_arr[rs] && (tag_arr[rs] == Reg_Reorder);

  always_comb begin
    busy    = 1'b0;
    reorder = '0;
    value   = '0;
    if (!rst && rs != 5'd0) begin
      busy    = busy_arr[rs];
      reorder = tag_arr[rs];
      value   = value_arr[rs];
      if (bypass) begin
        busy  = 1'b0;
        value = Reg_result;
      end
      if (clr) busy = 1'b0;
    end
  end
endmodule

module regfile #(
  parameter int REG_NUM    = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clr,
  input  logic                  Reg_write_S,
  input  logic [4:0]            Reg_rd,
  input  logic [ROB_WIDTH-1:0]  Reg_Reorder,
  input  logic [DATA_WIDTH-1:0] Reg_result,
  input  logic                  Dispatch_S,
  input  logic [4:0]            Dispatch_rd,
  input  logic [ROB_WIDTH-1:0]  Dispatch_Reorder,
  input  logic [4:0]            Dispatch_rs1,
  input  logic [4:0]            Dispatch_rs2,
  output logic                  rs1_busy,
  output logic [ROB_WIDTH-1:0]  rs1_Reorder,
  output logic [DATA_WIDTH-1:0] rs1_value,
  output logic                  rs2_busy,
  output logic [ROB_WIDTH-1:0]  rs2_Reorder,
  output logic [DATA_WIDTH-1:0] rs2_value
);
  localparam int NUM_RD = 2;

  logic [REG_NUM-1:0]                 busy_q;
  logic [REG_NUM-1:0][ROB_WIDTH-1:0]  tag_q;
  logic [REG_NUM-1:0][DATA_WIDTH-1:0] value_q;

  logic [NUM_RD-1:0][4:0]            rs_idx;
  logic [NUM_RD-1:0]                 rd_busy;
  logic [NUM_RD-1:0][ROB_WIDTH-1:0]  rd_tag;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_value;

  // Commit, then flush/rename. Later non-blocking writes win, so a rename or
  // flush overrides the commit's busy release while the value still lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      tag_q   <= '0;
      value_q <= '0;
    end else if (rdy) begin
      if (Reg_write_S && Reg_rd != 5'd0) begin
        value_q[Reg_rd] <= Reg_result;
        // Only the newest producer may release the register.
        if (busy_q[Reg_rd] && tag_q[Reg_rd] == Reg_Reorder)
          busy_q[Reg_rd] <= 1'b0;
      end
      if (clr) begin
        busy_q <= '0;
      end else if (Dispatch_S && Dispatch_rd != 5'd0) begin
        busy_q[Dispatch_rd] <= 1'b1;
        tag_q[Dispatch_rd]  <= Dispatch_Reorder;
      end
    end
  end

  assign rs_idx = {Dispatch_rs2, Dispatch_rs1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .REG_NUM    (REG_NUM),
      .ROB_WIDTH  (ROB_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_rd (
      .rst         (rst),
      .rdy         (rdy),
      .clr         (clr),
      .Reg_write_S (Reg_write_S),
      .Reg_rd      (Reg_rd),
      .Reg_Reorder (Reg_Reorder),
      .Reg_result  (Reg_result),
      .rs          (rs_idx[p]),
      .busy_arr    (busy_q),
      .tag_arr     (tag_q),
      .value_arr   (value_q),
      .busy        (rd_busy[p]),
      .reorder     (rd_tag[p]),
      .value       (rd_value[p])
    );
  end

  assign rs1_busy    = rd_busy[0];
  assign rs1_Reorder = rd_tag[0];
  assign rs1_value   = rd_value[0];
  assign rs2_busy    = rd_busy[1];
  assign rs2_Reorder = rd_tag[1];
  assign rs2_value   = rd_value[1];
endmodule

// File: doc/regfile.md
# regfile

Architectural register file with rename status for the Tomasulo core. It is the commit-side consumer of ROB retirements (`Reg_write_S`/`Reg_rd`/`Reg_Reorder`/`Reg_result`) and the rename-side producer of operand status for Dispatch. Each architectural register holds three fields: a committed value, a busy flag, and the ROB tag of its newest in-flight producer. All busy flags are dropped on a ROB flush (`clr`).

## Interface
- `REG_NUM`, 32: architectural registers; register 0 is hardwired to zero.
- `ROB_WIDTH`, 4: ROB tag width (16 entries).
- `DATA_WIDTH`, 32: register data width.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rdy` in 1: global ready; when 0, no state changes.
- `clr` in 1: ROB flush; clears all busy flags.
- `Reg_write_S` in 1: commit strobe from ROB.
- `Reg_rd` in 5: commit destination register.
- `Reg_Reorder` in ROB_WIDTH: ROB tag of the committing entry.
- `Reg_result` in DATA_WIDTH: committed value.
- `Dispatch_S` in 1: rename strobe for the instruction being dispatched.
- `Dispatch_rd` in 5: destination register of the dispatched instruction.
- `Dispatch_Reorder` in ROB_WIDTH: ROB tag allocated to it (ROB_nxt_pos).
- `Dispatch_rs1` in 5: first source register index.
- `Dispatch_rs2` in 5: second source register index.
- `rs1_busy` out 1: rs1 awaits an in-flight producer.
- `rs1_Reorder` out ROB_WIDTH: producer tag, meaningful only when busy.
- `rs1_value` out DATA_WIDTH: committed value, meaningful when not busy.
- `rs2_busy`, `rs2_Reorder`, `rs2_value`: same as the rs1 outputs, for rs2.

## Operation
State per register i: `value[i]`, `busy[i]`, `tag[i]`.

Reset (async, `rst`=1):
- All value, busy and tag fields go to 0 immediately.
- While `rst`=1, all six outputs read 0.

Clock-edge update, evaluated only when `rst`=0 and `rdy`=1:
- **Commit.** If `Reg_write_S`=1 and `Reg_rd`≠0, then `value[Reg_rd]` <= `Reg_result`.
  - Additionally, if `busy[Reg_rd]`=1 and `tag[Reg_rd]`==`Reg_Reorder`, then `busy[Reg_rd]` <= 0.
  - If the tags differ, a newer producer owns the register, so busy and tag are left unchanged.
- **Rename.** If `Dispatch_S`=1, `clr`=0 and `Dispatch_rd`≠0, then `busy[Dispatch_rd]` <= 1 and `tag[Dispatch_rd]` <= `Dispatch_Reorder`.
  - A same-cycle rename and commit to the same rd: rename wins for busy/tag; the commit still writes the value.
- **Flush.** If `clr`=1, every `busy[i]` <= 0. Dispatch is ignored that cycle. A commit presented in the same cycle (JAL/JALR retire together with the flush) still writes its value.
- **Register 0.** Never written, never busy; reads always return busy=0, tag=0, value=0.

Read port (combinational, per source rsN):
- **Bypass.** If `Reg_write_S`=1, `rdy`=1, `Reg_rd`==rsN≠0, `busy[rsN]`=1 and `tag[rsN]`==`Reg_Reorder`, output busy=0 and value=`Reg_result`. This keeps Dispatch from capturing a tag that retires this cycle.
- **Otherwise.** Output `busy[rsN]`, `tag[rsN]`, `value[rsN]`.
- **Own rename not visible.** A same-cycle rename of `Dispatch_rd` does not affect the reads, so `add x1,x1,x2` sees the prior mapping of x1.
- **Flush.** `clr`=1 forces busy outputs to 0; values still read from the array, with the commit bypass applied.

## Timing
- Reads: zero latency, combinational from the address and commit inputs.
- Commit and rename effects: visible on reads from the cycle after the edge.
- `rdy`=0: commit, rename and flush inputs are all ignored; state holds. The read ports stay live.
- Reset mid-operation: pending busy flags are discarded asynchronously; the first rename accepted is the one at the first edge after deassertion with `rdy`=1.
- Tag reuse across ROB wrap-around: safe, because busy is cleared only when the tag matches the latest rename.

## Test plan
- **Reset.** Hold `rst`=1 mid-run with x5 busy → all outputs 0 immediately; after release, rs1=5 reads busy=0, value=0.
- **Rename, then commit.** Dispatch rd=3, tag=7; next cycle rs1=3 → busy=1, Reorder=7. Commit rd=3, tag=7, result=0xDEADBEEF → same-cycle bypass gives busy=0, value=0xDEADBEEF; the next cycle reads the same from the array.
- **Stale commit.** Rename x4 to tag 2, then to tag 9; commit x4 with tag 2, value 0x11 → value=0x11, but busy stays 1 with tag 9; bypass does not fire.
- **Flush with JAL retire.** x1 renamed to tag 5, x6 to tag 6; assert `clr` with commit rd=1, tag=5, value 0x1004, plus `Dispatch_S` rd=8 → next cycle x1 reads 0x1004, all busy=0, x8 not busy.
- **Simultaneous commit and rename on one rd.** x2 busy with tag 3; commit x2/tag 3 value 0x55 while dispatching rd=2 tag 4 → next cycle busy=1, tag=4, value=0x55.
- **x0 and `rdy`.** Rename/commit rd=0 with value 0xFF → reads give 0, not busy. With `rdy`=0, a commit to x7 leaves x7 unchanged.
